// File: rtl/biu_master_if.sv
// Client request/done handshake and initiator-side bus signals for biu_master.
interface biu_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Client side
  logic                  biu_req;
  logic                  biu_rnw;
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic [DATA_WIDTH-1:0] biu_wdata;
  logic [BE_WIDTH-1:0]   biu_byteen;
  logic                  biu_ready;
  logic                  biu_done;
  logic [DATA_WIDTH-1:0] biu_rdata;
  logic                  biu_err;

  // Bus side
  logic                  bus_req;
  logic                  bus_rnw;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [BE_WIDTH-1:0]   bus_byteen;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  // View from the bus initiator
  modport master (
    input  biu_req, biu_rnw, biu_addr, biu_wdata, biu_byteen,
    output biu_ready, biu_done, biu_rdata, biu_err,
    output bus_req, bus_rnw, bus_addr, bus_wdata, bus_byteen,
    input  bus_ack, bus_rdata
  );

  // View from the surroundings (client plus responding slave)
  modport slave (
    output biu_req, biu_rnw, biu_addr, biu_wdata, biu_byteen,
    input  biu_ready, biu_done, biu_rdata, biu_err,
    input  bus_req, bus_rnw, bus_addr, bus_wdata, bus_byteen,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/biu_master.sv
// Bus initiator: takes one client request at a time, drives it on the bus until
// ack or timeout, then returns read data and error status with a done pulse.
module biu_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ALIGNED        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          n_rst,
  biu_master_if.master bif
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  // Keep at least one bit so a disabled timeout still elaborates cleanly
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  // Byte-offset bits of the address; a mask avoids a zero-width slice when DATA_WIDTH == 8
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e                state_q, state_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   byteen_q, byteen_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  misaligned;
  logic                  timeout_hit;

  // Request decode: alignment fault and timeout condition
  always_comb begin
    misaligned  = (ALIGNED != 0) && ((bif.biu_addr & ALIGN_MASK) != '0);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);
  end

  // Next-state logic: latch request, run bus phase, report completion
  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bif.biu_req) begin
          rnw_d    = bif.biu_rnw;
          addr_d   = bif.biu_addr;
          wdata_d  = bif.biu_wdata;
          byteen_d = bif.biu_byteen;
          cnt_d    = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a timeout landing in the same cycle
        if (bif.bus_ack) begin
          rdata_d = rnw_q ? bif.bus_rdata : '0;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    bif.biu_ready  = (state_q == StIdle);
    bif.biu_done   = (state_q == StDone);
    bif.biu_rdata  = rdata_q;
    bif.biu_err    = err_q;
    bif.bus_req    = (state_q == StBus);
    bif.bus_rnw    = rnw_q;
    bif.bus_addr   = addr_q;
    bif.bus_wdata  = wdata_q;
    bif.bus_byteen = byteen_q;
  end
endmodule

// File: tb/tb_biu_master.sv
// Directed bench for biu_master: write/read, misaligned reject, timeout,
// ack-at-timeout, stray ack, held request and mid-transaction reset.
module tb_biu_master;
  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  int   req_cycles;
  int   done_seen;
  int   done_cycle;

  biu_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  biu_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .ALIGNED       (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bif  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    bif.biu_req    = 1'b1;
    bif.biu_rnw    = rnw;
    bif.biu_addr   = addr;
    bif.biu_wdata  = wdata;
    bif.biu_byteen = be;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst  = 1'b0;
    bif.biu_req    = 1'b0;
    bif.biu_rnw    = 1'b0;
    bif.biu_addr   = '0;
    bif.biu_wdata  = '0;
    bif.biu_byteen = '0;
    bif.bus_ack    = 1'b0;
    bif.bus_rdata  = '0;
    tick();
    tick();
    check("rst_ready", bif.biu_ready, 1);
    check("rst_done", bif.biu_done, 0);
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_err", bif.biu_err, 0);
    check("rst_rdata", bif.biu_rdata, 0);
    n_rst = 1'b1;
    tick();

    // Write, ack on the second bus cycle
    issue(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    tick();  // cycle 1
    bif.biu_req = 1'b0;
    check("wr_c1_bus_req", bif.bus_req, 1);
    check("wr_c1_ready", bif.biu_ready, 0);
    check("wr_c1_addr", bif.bus_addr, 32'h8000_0000);
    check("wr_c1_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
    check("wr_c1_rnw", bif.bus_rnw, 0);
    tick();  // cycle 2
    check("wr_c2_bus_req", bif.bus_req, 1);
    check("wr_c2_addr", bif.bus_addr, 32'h8000_0000);
    check("wr_c2_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
    check("wr_c2_byteen", bif.bus_byteen, 4'hF);
    check("wr_c2_done", bif.biu_done, 0);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h5555_AAAA;  // ignored for a write
    tick();  // cycle 3
    bif.bus_ack = 1'b0;
    check("wr_c3_done", bif.biu_done, 1);
    check("wr_c3_err", bif.biu_err, 0);
    check("wr_c3_rdata", bif.biu_rdata, 0);
    check("wr_c3_bus_req", bif.bus_req, 0);
    check("wr_c3_ready", bif.biu_ready, 0);
    tick();  // cycle 4
    check("wr_c4_ready", bif.biu_ready, 1);
    check("wr_c4_done", bif.biu_done, 0);

    // Read, ack in the first bus cycle
    issue(1'b1, 32'h8000_0004, 32'h0, 4'hF);
    tick();  // cycle 1
    bif.biu_req = 1'b0;
    check("rd_c1_bus_req", bif.bus_req, 1);
    check("rd_c1_rnw", bif.bus_rnw, 1);
    check("rd_c1_addr", bif.bus_addr, 32'h8000_0004);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h1234_5678;
    tick();  // cycle 2
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    check("rd_c2_done", bif.biu_done, 1);
    check("rd_c2_rdata", bif.biu_rdata, 32'h1234_5678);
    check("rd_c2_err", bif.biu_err, 0);
    tick();  // cycle 3
    check("rd_c3_ready", bif.biu_ready, 1);
    check("rd_hold_rdata", bif.biu_rdata, 32'h1234_5678);

    // Misaligned read is rejected locally
    issue(1'b1, 32'h8000_0002, 32'h0, 4'hF);
    tick();  // cycle 1
    bif.biu_req = 1'b0;
    check("mis_c1_done", bif.biu_done, 1);
    check("mis_c1_err", bif.biu_err, 1);
    check("mis_c1_rdata", bif.biu_rdata, 0);
    check("mis_c1_bus_req", bif.bus_req, 0);
    tick();  // cycle 2
    check("mis_c2_ready", bif.biu_ready, 1);
    check("mis_c2_bus_req", bif.bus_req, 0);

    // Timeout with no ack: bus_req for exactly 16 cycles, done at cycle 17
    issue(1'b1, 32'h0000_0100, 32'h0, 4'hF);
    req_cycles = 0;
    done_seen  = 0;
    done_cycle = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      bif.biu_req = 1'b0;
      if (bif.bus_req) req_cycles++;
      if (bif.biu_done) begin
        done_seen  = 1;
        done_cycle = i;
        break;
      end
    end
    check("to_done_seen", done_seen, 1);
    check("to_req_cycles", req_cycles, 16);
    check("to_done_cycle", done_cycle, 17);
    check("to_err", bif.biu_err, 1);
    check("to_rdata", bif.biu_rdata, 0);
    tick();
    check("to_ready", bif.biu_ready, 1);

    // Ack on the 16th cycle wins over the timeout
    issue(1'b1, 32'h0000_0200, 32'h0, 4'hF);
    req_cycles = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      bif.biu_req = 1'b0;
      if (bif.bus_req) req_cycles++;
      if (i == 16) begin
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'hA5A5_5A5A;
      end
    end
    tick();  // cycle 17
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    check("ta_req_cycles", req_cycles, 16);
    check("ta_done", bif.biu_done, 1);
    check("ta_err", bif.biu_err, 0);
    check("ta_rdata", bif.biu_rdata, 32'hA5A5_5A5A);
    tick();

    // Stray ack while idle does nothing
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'hFFFF_FFFF;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bif.biu_done || bif.bus_req) done_seen = 1;
    end
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    check("stray_no_activity", done_seen, 0);
    check("stray_ready", bif.biu_ready, 1);

    // Request held while busy, reset in the third bus cycle
    issue(1'b0, 32'h0000_0300, 32'h0BAD_CAFE, 4'h3);
    tick();  // cycle 1
    check("hold_c1_bus_req", bif.bus_req, 1);
    check("hold_c1_ready", bif.biu_ready, 0);
    tick();  // cycle 2
    tick();  // cycle 3
    check("hold_c3_bus_req", bif.bus_req, 1);
    n_rst       = 1'b0;
    bif.biu_req = 1'b0;
    #1;
    check("arst_bus_req", bif.bus_req, 0);
    check("arst_ready", bif.biu_ready, 1);
    check("arst_done", bif.biu_done, 0);
    check("arst_addr", bif.bus_addr, 0);
    check("arst_wdata", bif.bus_wdata, 0);
    check("arst_rdata", bif.biu_rdata, 0);
    check("arst_err", bif.biu_err, 0);
    tick();
    n_rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bif.biu_done || bif.bus_req) done_seen = 1;
    end
    check("post_rst_quiet", done_seen, 0);

    // Next request after reset completes normally
    issue(1'b1, 32'h0000_0400, 32'h0, 4'hF);
    tick();  // cycle 1
    bif.biu_req = 1'b0;
    check("post_c1_bus_req", bif.bus_req, 1);
    check("post_c1_addr", bif.bus_addr, 32'h0000_0400);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'hCAFE_F00D;
    tick();  // cycle 2
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    check("post_c2_done", bif.biu_done, 1);
    check("post_c2_rdata", bif.biu_rdata, 32'hCAFE_F00D);
    check("post_c2_err", bif.biu_err, 0);
    tick();
    check("post_c3_ready", bif.biu_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/biu_master.md
Name: biu_master

Overview:
- Bus initiator, the requesting end of the shared bus that biu_slave responds on.
- Accepts single read/write requests from a local client through a request/done handshake.
- Drives each request onto the bus, holds it until the slave acks or a timeout expires, then returns read data and status to the client.
- One outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 32, address width of client and bus.
DATA_WIDTH, 32, data width; power of two, at least 8.
ALIGNED, 1, when 1 requests with addr[$clog2(DATA_WIDTH/8)-1:0] != 0 are rejected with error and never reach the bus.
TIMEOUT_CYCLES, 16, maximum cycles bus_req may stay high without bus_ack; 0 disables the timeout.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
biu_req  in  1  client request; accepted when biu_req && biu_ready
biu_rnw  in  1  1 = read, 0 = write
biu_addr  in  ADDR_WIDTH  request address
biu_wdata  in  DATA_WIDTH  write data
biu_byteen  in  DATA_WIDTH/8  byte enables
biu_ready  out  1  master idle, can accept a request
biu_done  out  1  one-cycle completion pulse
biu_rdata  out  DATA_WIDTH  read data, valid with biu_done
biu_err  out  1  error status, valid with biu_done
bus_req  out  1  bus transaction valid
bus_rnw  out  1  bus read/not-write
bus_addr  out  ADDR_WIDTH  bus address
bus_wdata  out  DATA_WIDTH  bus write data
bus_byteen  out  DATA_WIDTH/8  bus byte enables
bus_ack  in  1  slave completion; sampled only while bus_req=1
bus_rdata  in  DATA_WIDTH  slave read data, valid with bus_ack

Behaviour:
- Reset (n_rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 except biu_ready, which is 1 in IDLE.
  - Timeout counter is cleared.
  - Reset mid-transaction drops bus_req immediately and no biu_done is produced.
- States: IDLE, BUS, DONE. biu_ready = (state == IDLE).
- IDLE:
  - On accept, latch rnw, addr, wdata and byteen into registers.
  - If ALIGNED=1 and the address is misaligned: go to DONE with err=1 and rdata=0. bus_req stays 0.
  - Otherwise go to BUS.
- BUS:
  - bus_req=1; the bus_* fields come from the latched registers and are stable for the whole phase.
  - bus_req asserts the cycle after accept (registered).
  - Counter increments each BUS cycle.
- bus_ack=1 in BUS: capture bus_rdata (writes capture 0), err=0, go to DONE. bus_req drops the next cycle.
- Timeout: TIMEOUT_CYCLES>0, counter reaches TIMEOUT_CYCLES-1, and no ack that cycle → go to DONE with err=1 and rdata=0.
  - bus_req is high for exactly TIMEOUT_CYCLES cycles.
  - Ack in the same cycle as the timeout condition: ack wins, err=0.
- DONE:
  - biu_done=1 for exactly one cycle, with biu_rdata and biu_err valid; then go to IDLE.
  - biu_rdata and biu_err hold their value until the next biu_done.
- Latency: accept at cycle 0, ack sampled at cycle k (k>=1) → biu_done at k+1, biu_ready at k+2.
  - Misaligned: biu_done at cycle 1.
  - Minimum throughput is one transaction per 3 cycles.
- bus_ack outside BUS is ignored.
- biu_req while not ready is ignored; the client must hold it.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it is cleared on entering BUS.

Test Plan:
- Reset, then write addr=0x80000000, wdata=0xDEADBEEF, byteen=0xF; slave acks on the 2nd bus_req cycle → bus fields held stable; biu_done at cycle 3 with err=0; biu_ready back at cycle 4.
- Read addr=0x80000004; slave acks with rdata=0x12345678 in the first bus_req cycle → biu_done at cycle 2 with biu_rdata=0x12345678 and err=0.
- ALIGNED=1, read addr=0x80000002 → bus_req never asserts; biu_done at cycle 1 with err=1 and rdata=0.
- TIMEOUT_CYCLES=16, no ack → bus_req high exactly 16 cycles; biu_done with err=1. Repeat with ack on the 16th cycle → err=0 and data captured.
- Stray bus_ack while idle, biu_req held while busy, and reset asserted in the 3rd BUS cycle → no spurious biu_done; all outputs 0 with biu_ready=1 after reset; next request completes normally.
